// File: rtl/muldiv_sequencer_if.sv
// Handshake/bus bundle between the Execute/Decode stages and muldiv_sequencer.
// master = pipeline side (drives requests and operands), slave = sequencer.
// All signals are plain wires. The sequencer registers its own outputs.
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
  logic             StartE;
  logic [1:0]       OpE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             MthiE;
  logic             MtloE;
  logic             MdOpD;
  logic             MDStall;
  logic             Busy;
  logic             Done;
  logic             DivZero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output StartE, OpE, SrcAE, SrcBE, MthiE, MtloE, MdOpD,
    input  MDStall, Busy, Done, DivZero, HI, LO
  );

  modport slave (
    input  StartE, OpE, SrcAE, SrcBE, MthiE, MtloE, MdOpD,
    output MDStall, Busy, Done, DivZero, HI, LO
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU engine that owns HI/LO; the divide path is built only with MDU_DIV_EN.
// Latency: WIDTH+2 cycles from StartE to the Done pulse; MTHI/MTLO land one edge after issue.
// Backpressure: no ready; MDStall = (Busy | StartE) & MdOpD holds Decode/Fetch while a HI/LO user waits.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic              CLK,
  input  logic              RST,
  muldiv_sequencer_if.slave md
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;    // {upper, lower}: product, or {remainder, quotient}
  logic [WIDTH-1:0]   opb_q, opb_d;    // multiplicand or divisor magnitude
  logic               neg_q, neg_d;    // product/quotient needs negation in FIX
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               a_neg, b_neg, start_ok;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] step_acc, prod;
`ifdef MDU_DIV_EN
  logic               is_div_q, is_div_d;
  logic               rem_neg_q, rem_neg_d;
  logic               bzero_q, bzero_d;
  logic               divzero_q, divzero_d;
  logic [WIDTH:0]     rem_sh, div_diff;
  logic               div_neg;
  logic [WIDTH-1:0]   quo, rem;
`endif

  // Operand signs/magnitudes for signed ops and whether a start is accepted
  always_comb begin
    a_neg = md.OpE[0] & md.SrcAE[WIDTH-1];
    b_neg = md.OpE[0] & md.SrcBE[WIDTH-1];
    a_mag = a_neg ? -md.SrcAE : md.SrcAE;
    b_mag = b_neg ? -md.SrcBE : md.SrcBE;
`ifdef MDU_DIV_EN
    start_ok = md.StartE;
`else
    start_ok = md.StartE & ~md.OpE[1];
`endif
  end

  // One iteration: shift-add for multiply, restoring step for divide
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    step_acc = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    // A shifted remainder with its top bit set always exceeds the divisor
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff = rem_sh - {1'b0, opb_q};
    div_neg  = div_diff[WIDTH] & ~rem_sh[WIDTH];
    if (is_div_q) begin
      step_acc = {(div_neg ? rem_sh[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                  acc_q[WIDTH-2:0], ~div_neg};
    end
`endif
  end

  // Sign fix-up of the finished magnitudes
  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
`ifdef MDU_DIV_EN
    quo = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif
  end

  // Sequencer next state: IDLE accepts work or MTHI/MTLO, ITER runs WIDTH steps, FIX writes HI/LO
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef MDU_DIV_EN
    is_div_d  = is_div_q;
    rem_neg_d = rem_neg_q;
    bzero_d   = bzero_q;
    divzero_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d = ITER;
          cnt_d   = CW'(WIDTH - 1);
          acc_d   = {{WIDTH{1'b0}}, a_mag};
          opb_d   = b_mag;
          neg_d   = a_neg ^ b_neg;
          busy_d  = 1'b1;
`ifdef MDU_DIV_EN
          is_div_d  = md.OpE[1];
          rem_neg_d = a_neg;
          bzero_d   = (md.SrcBE == '0);
`endif
        end else begin
          if (md.MthiE) hi_d = md.SrcAE;
          if (md.MtloE) lo_d = md.SrcAE;
        end
      end
      ITER: begin
        acc_d = step_acc;
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      FIX: begin
        state_d      = IDLE;
        busy_d       = 1'b0;
        done_d       = 1'b1;
        {hi_d, lo_d} = prod;
`ifdef MDU_DIV_EN
        if (is_div_q) begin
          hi_d      = rem;
          lo_d      = quo;
          divzero_d = bzero_q;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset discards any in-flight result
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MDU_DIV_EN
      is_div_q  <= 1'b0;
      rem_neg_q <= 1'b0;
      bzero_q   <= 1'b0;
      divzero_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef MDU_DIV_EN
      is_div_q  <= is_div_d;
      rem_neg_q <= rem_neg_d;
      bzero_q   <= bzero_d;
      divzero_q <= divzero_d;
`endif
    end
  end

  assign md.HI      = hi_q;
  assign md.LO      = lo_q;
  assign md.Busy    = busy_q;
  assign md.Done    = done_q;
  assign md.MDStall = (busy_q | md.StartE) & md.MdOpD;
`ifdef MDU_DIV_EN
  assign md.DivZero = divzero_q;
`else
  assign md.DivZero = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed vectors, an arithmetic reference model checked every cycle,
// plus literal expectations for the headline cases. Divide cases follow MDU_DIV_EN.
module tb_muldiv_sequencer;
  localparam int W = 32;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;

  muldiv_sequencer_if #(.WIDTH(W)) bus ();
  muldiv_sequencer #(.WIDTH(W)) dut (.CLK(CLK), .RST(RST), .md(bus));

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the ISA definition
  function automatic void ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo, output bit dz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      2'b10: begin
        dz = (b == 0);
        if (dz) begin hi = a; lo = 32'hFFFF_FFFF; end
        else begin hi = a % b; lo = a / b; end
      end
      default: begin
        dz = (b == 0);
        if (dz) begin hi = a; lo = a[31] ? 32'h1 : 32'hFFFF_FFFF; end
        else begin q = sa / sb; r = sa % sb; lo = 32'(q); hi = 32'(r); end
      end
    endcase
  endfunction

  // Cycle model: what HI/LO/Busy/Done/DivZero must be after each edge
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_cnt = 0;
  bit          m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
  bit          chk_en = 1'b0;

  always @(posedge CLK) begin
    if (RST) begin
      m_hi = '0; m_lo = '0; m_cnt = 0; m_done = 1'b0; m_dz = 1'b0;
    end else begin
      m_done = 1'b0;
      m_dz   = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; m_dz = p_dz;
        end
      end else if (bus.StartE && (DIV_EN || !bus.OpE[1])) begin
        ref_result(bus.OpE, bus.SrcAE, bus.SrcBE, p_hi, p_lo, p_dz);
        m_cnt = W + 1;
      end else begin
        if (bus.MthiE) m_hi = bus.SrcAE;
        if (bus.MtloE) m_lo = bus.SrcAE;
      end
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge CLK) begin
    if (chk_en) begin
      check("cyc_hi", bus.HI, m_hi);
      check("cyc_lo", bus.LO, m_lo);
      check("cyc_busy", bus.Busy, m_cnt > 0);
      check("cyc_done", bus.Done, m_done);
      check("cyc_divzero", bus.DivZero, m_dz);
      check("cyc_mdstall", bus.MDStall, ((m_cnt > 0) || bus.StartE) && bus.MdOpD);
      assert (!(bus.StartE && bus.Busy)) else begin
        errors++;
        $display("FAIL protocol: StartE while Busy (t=%0t)", $time);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Present one op in cycle T; returns in cycle T+1 with MDStall as seen in cycle T
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit mdop, output bit stall_t);
    bus.StartE = 1'b1; bus.OpE = op; bus.SrcAE = a; bus.SrcBE = b; bus.MdOpD = mdop;
    #1;
    stall_t = bus.MDStall;
    @(posedge CLK);
    #1;
    bus.StartE = 1'b0;
  endtask

  // Bounded wait for Done; lat counts cycles since T
  task automatic wait_done(output int lat, output int busy_n, output int stall_n);
    lat = 1; busy_n = 0; stall_n = 0;
    while (!bus.Done && lat < 60) begin
      if (bus.Busy) busy_n++;
      if (bus.MDStall) stall_n++;
      step();
      lat++;
    end
    if (!bus.Done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no Done within %0d cycles", lat);
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input bit exp_dz);
    bit st;
    int lat, bn, sn;
    issue(op, a, b, 1'b0, st);
    wait_done(lat, bn, sn);
    check({name, "_lat"}, lat, 34);
    check({name, "_hi"}, bus.HI, exp_hi);
    check({name, "_lo"}, bus.LO, exp_lo);
    check({name, "_dz"}, bus.DivZero, exp_dz);
  endtask

  initial begin
    bit st;
    int lat, bn, sn, cnt_b, cnt_d;
    bus.StartE = 1'b0; bus.OpE = 2'b00; bus.SrcAE = '0; bus.SrcBE = '0;
    bus.MthiE = 1'b0; bus.MtloE = 1'b0; bus.MdOpD = 1'b0;

    // Reset values
    repeat (3) step();
    check("rst_hi", bus.HI, 0);
    check("rst_lo", bus.LO, 0);
    check("rst_busy", bus.Busy, 0);
    check("rst_done", bus.Done, 0);
    check("rst_divzero", bus.DivZero, 0);
    check("rst_mdstall", bus.MDStall, 0);
    RST = 1'b0;
    chk_en = 1'b1;
    step();

    // MULTU all-ones: latency and Busy window
    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, st);
    wait_done(lat, bn, sn);
    check("multu_lat", lat, 34);
    check("multu_busy_cycles", bn, 33);
    check("multu_hi", bus.HI, 32'hFFFF_FFFE);
    check("multu_lo", bus.LO, 32'h0000_0001);

    // Back-to-back start in the Done cycle
    run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

    // MULT most-negative squared with an mflo waiting in Decode
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b1, st);
    check("stall_at_issue", st, 1);
    wait_done(lat, bn, sn);
    check("stall_cycles", sn + 1, 34);
    check("stall_released", bus.MDStall, 0);
    check("mult_min_hi", bus.HI, 32'h4000_0000);
    check("mult_min_lo", bus.LO, 32'h0000_0000);
    bus.MdOpD = 1'b0;
    step();

    if (DIV_EN) begin
      run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run_op("divu_zero", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
      run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
      run_op("divu_plain", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    end else begin
      // Divide absent: preload HI/LO, then DIVU must be a no-op
      bus.MthiE = 1'b1; bus.MtloE = 1'b1; bus.SrcAE = 32'h0000_AAAA;
      step();
      bus.MthiE = 1'b0; bus.MtloE = 1'b0;
      issue(2'b10, 32'd9, 32'd3, 1'b0, st);
      cnt_b = 0; cnt_d = 0;
      repeat (40) begin
        if (bus.Busy) cnt_b++;
        if (bus.Done) cnt_d++;
        step();
      end
      check("nodiv_busy", cnt_b, 0);
      check("nodiv_done", cnt_d, 0);
      check("nodiv_hi", bus.HI, 32'h0000_AAAA);
      check("nodiv_lo", bus.LO, 32'h0000_AAAA);
    end

    // Reset at T+10 of an operation discards it
    issue(DIV_EN ? 2'b11 : 2'b01, 32'd100, 32'd7, 1'b0, st);
    repeat (9) step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("midrst_hi", bus.HI, 0);
    check("midrst_lo", bus.LO, 0);
    check("midrst_busy", bus.Busy, 0);
    cnt_d = 0;
    repeat (40) begin
      if (bus.Done) cnt_d++;
      step();
    end
    check("midrst_no_done", cnt_d, 0);

    // MTLO then MTHI, each visible one edge after issue
    bus.MtloE = 1'b1; bus.SrcAE = 32'h0000_1234;
    step();
    bus.MtloE = 1'b0;
    check("mtlo", bus.LO, 32'h0000_1234);
    bus.MthiE = 1'b1; bus.SrcAE = 32'hDEAD_BEEF;
    step();
    bus.MthiE = 1'b0;
    check("mthi", bus.HI, 32'hDEAD_BEEF);
    check("mthi_lo_kept", bus.LO, 32'h0000_1234);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
